// File: rtl/ex_alu_stage_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and the
// operand-A select values. The ALU control decoder imports this package
// as well, so both sides always agree on the encodings.
package ex_alu_stage_pkg;

    // ALU operation codes. Codes 4'hD..4'hF are unused and produce zero.
    typedef enum logic [3:0] {
        ALU_SLL = 4'h0,  // B << A[4:0]
        ALU_SRL = 4'h1,  // B >> A[4:0], logical
        ALU_SRA = 4'h2,  // B >>> A[4:0], arithmetic
        ALU_ADD = 4'h3,  // A + B, wraps
        ALU_SUB = 4'h4,  // A - B, wraps
        ALU_AND = 4'h5,
        ALU_OR  = 4'h6,
        ALU_XOR = 4'h7,
        ALU_NOR = 4'h8,
        ALU_SLT = 4'h9,  // signed A < B
        ALU_LUI = 4'hA,  // B << 16
        ALU_BEQ = 4'hB,  // A - B, branch when A == B
        ALU_BNE = 4'hC   // A - B, branch when A != B
    } alu_op_e;

    // Operand-A select: the instruction shamt field or the rs value.
    localparam logic SHAMT_SEL_FIELD  = 1'b0;
    localparam logic SHAMT_SEL_DATA_A = 1'b1;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational ALU datapath: operands and operation code in, result and
// raw branch condition out. No state lives here.
module alu_core
    import ex_alu_stage_pkg::*;
#(
    parameter int DATA_SIZE     = 32,
    parameter int ALU_CTRL_SIZE = 4,
    parameter int SHAMT_SIZE    = 5
) (
    input  logic [DATA_SIZE-1:0]     i_a,
    input  logic [DATA_SIZE-1:0]     i_b,
    input  logic [ALU_CTRL_SIZE-1:0] i_op,
    output logic [DATA_SIZE-1:0]     o_result,
    output logic                     o_branch_cond
);

    logic [SHAMT_SIZE-1:0] shift_amt;
    logic                  slt_bit;

    // Shifts only look at the low bits of operand A.
    assign shift_amt = i_a[SHAMT_SIZE-1:0];
    assign slt_bit   = ($signed(i_a) < $signed(i_b));

    // Result selection by operation code; unused codes give zero.
    always_comb begin
        o_result = '0;
        case (alu_op_e'(i_op))
            ALU_SLL: o_result = i_b << shift_amt;
            ALU_SRL: o_result = i_b >> shift_amt;
            ALU_SRA: o_result = DATA_SIZE'($signed(i_b) >>> shift_amt);
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_SLT: o_result = {{(DATA_SIZE-1){1'b0}}, slt_bit};
            ALU_LUI: o_result = i_b << 16;
            ALU_BEQ: o_result = i_a - i_b;
            ALU_BNE: o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end

    // Raw branch condition; the stage gates it with valid and link.
    always_comb begin
        o_branch_cond = 1'b0;
        case (alu_op_e'(i_op))
            ALU_BEQ: o_branch_cond = (i_a == i_b);
            ALU_BNE: o_branch_cond = (i_a != i_b);
            default: o_branch_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: operand-A mux, link-address override, ALU, and the
// EX/MEM pipeline register with reset > flush > stall > load priority.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
#(
    parameter int DATA_SIZE     = 32,
    parameter int ALU_CTRL_SIZE = 4,
    parameter int SHAMT_SIZE    = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic [ALU_CTRL_SIZE-1:0] i_alu_ctrl,
    input  logic                     i_shamt_ctrl,
    input  logic                     i_last_register_ctrl,
    input  logic [DATA_SIZE-1:0]     i_data_a,
    input  logic [DATA_SIZE-1:0]     i_data_b,
    input  logic [SHAMT_SIZE-1:0]    i_shamt,
    input  logic [DATA_SIZE-1:0]     i_return_addr,
    output logic [DATA_SIZE-1:0]     o_result,
    output logic                     o_zero,
    output logic                     o_branch_taken,
    output logic                     o_valid
);

    logic [DATA_SIZE-1:0] operand_a;
    logic [DATA_SIZE-1:0] alu_result;
    logic                 alu_branch_cond;

    logic [DATA_SIZE-1:0] result_d, result_q;
    logic                 zero_d, zero_q;
    logic                 branch_d, branch_q;
    logic                 valid_d, valid_q;

    // Operand A is either the zero-extended shamt field or rs.
    always_comb begin
        operand_a = i_data_a;
        if (i_shamt_ctrl == SHAMT_SEL_FIELD) begin
            operand_a = {{(DATA_SIZE-SHAMT_SIZE){1'b0}}, i_shamt};
        end
    end

    alu_core #(
        .DATA_SIZE    (DATA_SIZE),
        .ALU_CTRL_SIZE(ALU_CTRL_SIZE),
        .SHAMT_SIZE   (SHAMT_SIZE)
    ) u_alu_core (
        .i_a          (operand_a),
        .i_b          (i_data_b),
        .i_op         (i_alu_ctrl),
        .o_result     (alu_result),
        .o_branch_cond(alu_branch_cond)
    );

    // Next-state values for a normal load: link override wins over the ALU,
    // and a branch is only taken by a live, non-link instruction.
    always_comb begin
        result_d = i_last_register_ctrl ? i_return_addr : alu_result;
        zero_d   = (result_d == '0);
        branch_d = i_valid & ~i_last_register_ctrl & alu_branch_cond;
        valid_d  = i_valid;
    end

    // EX/MEM register: reset and flush both insert a bubble; stall holds.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            branch_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (!i_stall) begin
            result_q <= result_d;
            zero_q   <= zero_d;
            branch_q <= branch_d;
            valid_q  <= valid_d;
        end
    end

    assign o_result       = result_q;
    assign o_zero         = zero_q;
    assign o_branch_taken = branch_q;
    assign o_valid        = valid_q;

endmodule

// File: doc/ex_alu_stage.md
EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 Parameter DATA_SIZE, 32, operand/result width.
REQ-002 Parameter ALU_CTRL_SIZE, 4, width of ALU operation code.
REQ-003 Parameter SHAMT_SIZE, 5, shift-amount field width.
REQ-004 i_clk  input  1  single clock, all state on rising edge.
REQ-005 i_reset  input  1  reset, synchronous and active-high.
REQ-006 i_valid  input  1  ID/EX slot holds a live instruction.
REQ-007 i_stall  input  1  hold EX/MEM register contents.
REQ-008 i_flush  input  1  squash: next EX/MEM slot becomes bubble.
REQ-009 i_alu_ctrl  input  4  operation code from ALU control decoder.
REQ-010 i_shamt_ctrl  input  1  operand-A select: 0 shamt field, 1 data_a.
REQ-011 i_last_register_ctrl  input  1  link select: result is return address.
REQ-012 i_data_a  input  32  rs value.
REQ-013 i_data_b  input  32  rt value or extended immediate (selected upstream).
REQ-014 i_shamt  input  5  instruction shamt field.
REQ-015 i_return_addr  input  32  link address for JAL/JALR.
REQ-016 o_result  output  32  registered ALU result (EX/MEM).
REQ-017 o_zero  output  1  registered: result equals zero.
REQ-018 o_branch_taken  output  1  registered branch decision.
REQ-019 o_valid  output  1  registered: EX/MEM slot live.

Function
REQ-020 Operand A SHALL be {27'b0, i_shamt} when i_shamt_ctrl=0, else i_data_a.
REQ-021 Codes SHALL compute: 0 B<<A[4:0]; 1 B>>A[4:0] logical; 2 B>>>A[4:0] arithmetic; 3 A+B; 4 A-B; 5 A&B; 6 A|B; 7 A^B; 8 ~(A|B); 9 signed A<B ? 1 : 0; A B<<16; B A-B; C A-B.
REQ-022 Codes D-F SHALL yield result 0, branch_taken 0.
REQ-023 Add/subtract SHALL wrap modulo 2^32; no overflow trap or flag.
REQ-024 Branch decision SHALL be (A==B) for code B and (A!=B) for code C, 0 otherwise, gated by i_valid.
REQ-025 i_last_register_ctrl=1 SHALL override result with i_return_addr, branch_taken 0, regardless of code.
REQ-026 Latency SHALL be exactly one cycle: inputs sampled on edge N appear on outputs after edge N.
REQ-027 Priority per edge: reset > flush > stall > load.
REQ-028 Flush SHALL load o_valid=0, o_branch_taken=0, o_result=0, o_zero=1.
REQ-029 Stall without flush SHALL hold all outputs unchanged, including o_valid.
REQ-030 i_valid=0 on load SHALL register o_valid=0 and o_branch_taken=0; o_result computed normally.
REQ-031 o_zero SHALL reflect the registered o_result value, including link override.

Reset
REQ-032 i_reset high on an edge SHALL set o_result=0, o_zero=1, o_branch_taken=0, o_valid=0.
REQ-033 Reset asserted while stalled SHALL still clear all outputs; reset mid-stream discards the in-flight instruction.

Structure
REQ-034 ALU operation codes 0-C and shamt-select encodings SHALL be defined in the shared parameters header, shared with the ALU control decoder.
REQ-035 Combinational datapath SHALL be sub-module alu_core (operands, code -> result, branch condition); ex_alu_stage holds operand mux, link override and EX/MEM register.

Verification
REQ-036 Reset then code 3, shamt_ctrl=1, A=0x7FFFFFFF, B=1, valid -> next cycle o_result=0x80000000, o_zero=0, o_valid=1.
REQ-037 Code 2, shamt_ctrl=0, shamt=4, B=0xF0000000 -> 0xFF000000; code 2, shamt_ctrl=1, A=0x24, B=0x80000000 -> 0xF8000000 (A[4:0]=4).
REQ-038 Code B, A=B=5, valid -> branch_taken=1, o_zero=1; code C same operands -> branch_taken=0; code B with valid=0 -> branch_taken=0.
REQ-039 Load 0x11 result, then stall 3 cycles with new inputs -> o_result stays 0x11; assert stall+flush together -> o_valid=0, o_result=0.
REQ-040 Code 0 with last_register_ctrl=1, return_addr=0x00000108 -> o_result=0x108, branch_taken=0; code A, B=0x1234 -> 0x12340000; code 9, A=0xFFFFFFFF, B=1 -> 1.
